alu32_rr_sched: RTL and testbench
=================================

// Module: alu32_rr_sched
// PURPOSE
// - Shares one 32-bit ALU (AND/OR/XOR/XNOR/ADD/SUB/NOT datapath) among NREQ requesters.
// - Round-robin grant; the operation and operands are latched and held stable at the ALU for ALU_LAT cycles.
// - The result and NZCV flags are registered and returned with the requester id over a valid/ready response port.
// - Sits between client units (decode, address-gen, test engine) and the shared ALU32 instance.
// PARAMETERS
// - NREQ     4   number of requesters (2..8)
// - IDW      2   requester id width, clog2(NREQ), min 1
// - ALU_LAT  1   cycles operands are held before capture (1..15)
// PORTS
// - clk         in   1          rising-edge clock; the only clock
// - reset_n     in   1          asynchronous active-low reset
// - req_valid   in   NREQ       per-requester request valid
// - req_ready   out  NREQ       per-requester accept; at most one bit high (onehot0)
// - req_op      in   3*NREQ     op of requester i at [3i+2:3i]
// - req_a       in   32*NREQ    operand A of requester i at [32i+31:32i]
// - req_b       in   32*NREQ    operand B, same packing as req_a
// - alu_op      out  3          op to ALU, held during EXEC
// - alu_a       out  32         operand A to ALU
// - alu_b       out  32         operand B to ALU
// - alu_result  in   32         ALU result
// - alu_nzcv    in   4          ALU flags {N,Z,C,V}
// - rsp_valid   out  1          response valid
// - rsp_ready   in   1          response accept
// - rsp_id      out  IDW        index of the requester served
// - rsp_result  out  32         captured result
// - rsp_nzcv    out  4          captured flags
// - rsp_err     out  1          1 = illegal op (3'b111)
// - busy        out  1          state != IDLE
// BEHAVIOUR
// - Reset (async, on reset_n low):
//   - state=IDLE, ptr=0, cnt=0.
//   - All outputs 0: req_ready, alu_*, rsp_*, busy.
//   - Reset mid-op discards the op silently; no response.
// - FSM states: IDLE, EXEC, RESP.
// - IDLE:
//   - g = first i with req_valid[i], searching from ptr upward, wrapping modulo NREQ.
//   - req_ready[g]=1 combinationally in the same cycle.
//   - On the clock edge, latch op/a/b/g.
//   - op != 7: go to EXEC with cnt=ALU_LAT-1.
//   - op == 7: go to RESP with result=0, nzcv=0, err=1. The ALU is not driven.
// - EXEC:
//   - alu_op/a/b = latched values, stable for exactly ALU_LAT cycles.
//   - cnt decrements each cycle.
//   - In the cycle where cnt==0, capture alu_result/alu_nzcv on the edge, err=0, then go to RESP.
// - RESP:
//   - rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready.
//   - On handshake: go to IDLE and set ptr = (g+1) mod NREQ.
//   - No new grant in the handshake cycle.
// - Outside EXEC, alu_op/a/b return to 0.
// - req_ready is 0 in EXEC and RESP.
// - Latency: accept edge to rsp_valid = ALU_LAT+1 cycles.
// - Max throughput: one op per ALU_LAT+2 cycles.
// - Fairness: with all requesters valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 ops.
// - req_valid changes in IDLE are re-arbitrated every cycle. After acceptance, req_* are ignored.
// - Unused id codes (NREQ < 2^IDW) never appear.
// STRUCTURE
// - Package alu32_pkg:
//   - op codes: AND=0, OR=1, XOR=2, XNOR=3, ADD=4, SUB=5, NOTA=6, ILL=7.
//   - state encoding IDLE/EXEC/RESP.
//   - NZCV bit positions.
// - Sub-module alu32_rr_arb: combinational NREQ round-robin picker (req, ptr -> onehot grant, index, any).
// - The top holds the FSM, counter, operand/response registers and the ptr register.
// TESTING
// - Reset with req_valid=4'b1111 held: all outputs 0. First grant after release goes to id 0.
// - Single req1 ADD a=32'hFFFF_FFFF b=1, ALU_LAT=1:
//   - rsp_valid 2 cycles after accept.
//   - rsp_result=0, nzcv=4'b0110, rsp_id=1.
// - All four requesters valid continuously, rsp_ready=1: rsp_id sequence 0,1,2,3,0 with 3 cycles/op.
// - Illegal op 3'b111 from req2: alu_* stay 0; rsp_err=1, rsp_result=0, next-cycle rsp_valid.
// - rsp_ready held 0 for 5 cycles after rsp_valid:
//   - rsp_* stable, req_ready all 0.
//   - Grant resumes the cycle after the handshake.
// - reset_n pulsed low during EXEC (ALU_LAT=4, SUB 5-7): no response. ptr=0 and IDLE afterwards.

Source files
------------

// File: rtl/alu32_rr_sched_pkg.sv
// Shared definitions for the round-robin ALU32 scheduler: op codes, FSM states,
// flag bit positions and the latched operand bundle.
package alu32_pkg;
   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_XNOR = 3'd3,
      OP_ADD  = 3'd4,
      OP_SUB  = 3'd5,
      OP_NOTA = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } alu_req_t;
endpackage

// File: rtl/alu32_rr_sched_if.sv
// Request, ALU and response bundle between client units and the shared ALU scheduler.
interface alu32_rr_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [3*NREQ-1:0]  req_op;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [2:0]         alu_op;
   logic [31:0]        alu_a;
   logic [31:0]        alu_b;
   logic [31:0]        alu_result;
   logic [3:0]         alu_nzcv;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [31:0]        rsp_result;
   logic [3:0]         rsp_nzcv;
   logic               rsp_err;
   logic               busy;

   modport slave (
      input  req_valid, req_op, req_a, req_b, alu_result, alu_nzcv, rsp_ready,
      output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result,
             rsp_nzcv, rsp_err, busy
   );

   modport master (
      output req_valid, req_op, req_a, req_b, alu_result, alu_nzcv, rsp_ready,
      input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result,
             rsp_nzcv, rsp_err, busy
   );
endinterface

// File: rtl/alu32_rr_arb.sv
// Combinational round-robin picker: first valid requester at or above ptr,
// wrapping modulo NREQ.
module alu32_rr_arb
   import alu32_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);
   always_comb begin
      int j;
      j       = 0;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(i_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!o_any && i_req[j]) begin
            o_any      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = IDW'(j);
         end
      end
   end
endmodule

// File: rtl/alu32_rr_sched.sv
// Shares one ALU32 among NREQ requesters: round-robin grant, operands held for
// ALU_LAT cycles, result/flags returned with the requester id.
module alu32_rr_sched
   import alu32_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int ALU_LAT = 1
) (
   input  logic            clk,
   input  logic            reset_n,
   alu32_rr_sched_if.slave bus
);
   state_e          r_state;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic [3:0]      r_cnt;
   alu_req_t        r_req;
   logic [31:0]     r_result;
   logic [3:0]      r_nzcv;
   logic            r_err;

   logic [NREQ-1:0] w_grant;
   logic [IDW-1:0]  w_idx;
   logic            w_any;
   alu_req_t        w_sel [NREQ];
   alu_req_t        w_req;

   for (genvar i = 0; i < NREQ; i++) begin : g_sel
      assign w_sel[i] = {bus.req_op[3*i +: 3], bus.req_a[32*i +: 32], bus.req_b[32*i +: 32]};
   end

   alu32_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .i_req   (bus.req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_req = w_sel[w_idx];

   // Gated by reset_n so no requester sees an accept while reset is held.
   assign bus.req_ready  = (r_state == IDLE && reset_n) ? w_grant : '0;
   assign bus.alu_op     = (r_state == EXEC) ? r_req.op : 3'd0;
   assign bus.alu_a      = (r_state == EXEC) ? r_req.a  : 32'd0;
   assign bus.alu_b      = (r_state == EXEC) ? r_req.b  : 32'd0;
   assign bus.rsp_valid  = (r_state == RESP);
   assign bus.rsp_id     = r_id;
   assign bus.rsp_result = r_result;
   assign bus.rsp_nzcv   = r_nzcv;
   assign bus.rsp_err    = r_err;
   assign bus.busy       = (r_state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_ptr    <= '0;
         r_id     <= '0;
         r_cnt    <= '0;
         r_req    <= '0;
         r_result <= '0;
         r_nzcv   <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_req <= w_req;
               r_id  <= w_idx;
               // Illegal op never reaches the ALU; answer straight away.
               if (w_req.op == OP_ILL) begin
                  r_result <= '0;
                  r_nzcv   <= '0;
                  r_err    <= 1'b1;
                  r_state  <= RESP;
               end else begin
                  r_cnt   <= 4'(ALU_LAT - 1);
                  r_state <= EXEC;
               end
            end
            EXEC: if (r_cnt == 4'd0) begin
               r_result <= bus.alu_result;
               r_nzcv   <= bus.alu_nzcv;
               r_err    <= 1'b0;
               r_state  <= RESP;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
            RESP: if (bus.rsp_ready) begin
               r_state <= IDLE;
               r_ptr   <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu32_rr_sched.sv
// Scoreboard bench for alu32_rr_sched: bench-side ALU model, round-robin model,
// expected responses queued at grant and compared at response.
module tb_alu32_rr_sched;
   import alu32_pkg::*;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] res;
      logic [3:0]  nzcv;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n, reset_n4, rdy, rdy4;
   logic [3:0]  v, v4;
   logic [2:0]  op [4];
   logic [31:0] a [4];
   logic [31:0] b [4];
   logic [2:0]  op4 [4];
   logic [31:0] a4 [4];
   logic [31:0] b4 [4];

   int   n_chk = 0;
   int   n_fail = 0;
   int   exp_ptr = 0;
   exp_t q[$];

   alu32_rr_sched_if #(.NREQ(4), .IDW(2)) bus ();
   alu32_rr_sched_if #(.NREQ(4), .IDW(2)) bus4 ();

   alu32_rr_sched #(.NREQ(4), .IDW(2), .ALU_LAT(1)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));
   alu32_rr_sched #(.NREQ(4), .IDW(2), .ALU_LAT(4)) dut4 (
      .clk(clk), .reset_n(reset_n4), .bus(bus4));

   function automatic logic [35:0] alu_model(logic [2:0] o, logic [31:0] x, logic [31:0] y);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, ov;
      s = '0; r = '0; c = 1'b0; ov = 1'b0;
      case (o)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: r = x ^ y;
         3'd3: r = ~(x ^ y);
         3'd4: begin s = {1'b0, x} + {1'b0, y}; r = s[31:0]; c = s[32];
                     ov = (x[31] == y[31]) && (r[31] != x[31]); end
         3'd5: begin s = {1'b0, x} - {1'b0, y}; r = s[31:0]; c = ~s[32];
                     ov = (x[31] != y[31]) && (r[31] != x[31]); end
         3'd6: r = ~x;
         default: return 36'd0;
      endcase
      return {r[31], (r == 32'd0), c, ov, r};
   endfunction

   always_comb begin
      {bus.alu_nzcv, bus.alu_result}   = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);
      {bus4.alu_nzcv, bus4.alu_result} = alu_model(bus4.alu_op, bus4.alu_a, bus4.alu_b);
      for (int i = 0; i < 4; i++) begin
         bus.req_op[3*i +: 3]   = op[i];
         bus.req_a[32*i +: 32]  = a[i];
         bus.req_b[32*i +: 32]  = b[i];
         bus4.req_op[3*i +: 3]  = op4[i];
         bus4.req_a[32*i +: 32] = a4[i];
         bus4.req_b[32*i +: 32] = b4[i];
      end
      bus.req_valid  = v;
      bus4.req_valid = v4;
   end
   assign bus.rsp_ready  = rdy;
   assign bus4.rsp_ready = rdy4;

   function automatic int pick(logic [3:0] vv, int p);
      for (int k = 0; k < 4; k++)
         if (vv[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   function automatic exp_t mk(int g);
      logic [35:0] m;
      m = alu_model(op[g], a[g], b[g]);
      mk.id   = 2'(g);
      mk.res  = m[31:0];
      mk.nzcv = m[35:32];
      mk.err  = (op[g] == 3'b111);
   endfunction

   task automatic pt();
      @(negedge clk); #1;
   endtask

   task automatic wait_rsp(output int n);
      n = -1;
      for (int k = 1; k <= 20; k++) begin
         pt();
         if (bus.rsp_valid) begin n = k; return; end
      end
   endtask

   task automatic test_reset();
      exp_t e; int n;
      reset_n = 1'b0; reset_n4 = 1'b0; rdy = 1'b1; rdy4 = 1'b1; v = 4'b1111; v4 = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         op[i] = OP_ADD; a[i] = 32'h100 * (i + 1); b[i] = 32'(i + 7);
         op4[i] = OP_AND; a4[i] = 32'd0; b4[i] = 32'd0;
      end
      repeat (3) pt();
      n_chk++;
      if ({bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err} !== 7'd0) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 0", {bus.req_ready, bus.rsp_valid, bus.busy, bus.rsp_err});
      end
      n_chk++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 67'd0) begin
         n_fail++; $display("FAIL reset_alu: got %h want 0", {bus.alu_op, bus.alu_a, bus.alu_b});
      end
      n_chk++;
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_nzcv} !== 38'd0) begin
         n_fail++; $display("FAIL reset_rsp: got %h want 0", {bus.rsp_id, bus.rsp_result, bus.rsp_nzcv});
      end
      reset_n = 1'b1; reset_n4 = 1'b1; exp_ptr = 0; #1;
      n_chk++;
      if (bus.req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL first_grant: got %b want 0001", bus.req_ready);
      end
      q.push_back(mk(0));
      pt(); v = 4'b0000;
      wait_rsp(n);
      n_chk++;
      if (n !== 1) begin n_fail++; $display("FAIL reset_op_latency: got %0d want 1", n); end
      if (n > 0) begin
         e = q.pop_front();
         n_chk++;
         if ({bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err} !== {e.id, e.res, e.nzcv, e.err}) begin
            n_fail++; $display("FAIL reset_op_rsp: got %h want %h",
               {bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err}, {e.id, e.res, e.nzcv, e.err});
         end
         exp_ptr = (int'(e.id) + 1) % 4;
      end
      pt();
   endtask

   task automatic test_single_add();
      exp_t e; int n;
      op[1] = OP_ADD; a[1] = 32'hFFFF_FFFF; b[1] = 32'd1; v = 4'b0010; #1;
      n_chk++;
      if (bus.req_ready !== 4'(1 << pick(v, exp_ptr))) begin
         n_fail++; $display("FAIL add_grant: got %b want %b", bus.req_ready, 4'(1 << pick(v, exp_ptr)));
      end
      q.push_back(mk(1));
      pt(); v = 4'b0000;
      n_chk++;
      if ({bus.busy, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1}) begin
         n_fail++; $display("FAIL add_exec: got %h want %h", {bus.busy, bus.alu_op, bus.alu_a, bus.alu_b},
            {1'b1, 3'd4, 32'hFFFF_FFFF, 32'd1});
      end
      wait_rsp(n);
      n_chk++;
      if (n + 1 !== 2) begin n_fail++; $display("FAIL add_latency: got %0d want 2", n + 1); end
      n_chk++;
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err} !== {2'd1, 32'd0, 4'b0110, 1'b0}) begin
         n_fail++; $display("FAIL add_rsp: got id=%0d res=%h nzcv=%b err=%b want id=1 res=0 nzcv=0110 err=0",
            bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err);
      end
      e = q.pop_front();
      n_chk++;
      if (bus.rsp_nzcv[NZCV_C] !== e.nzcv[NZCV_C] || bus.rsp_nzcv[NZCV_Z] !== e.nzcv[NZCV_Z]) begin
         n_fail++; $display("FAIL add_flags: got %b want %b", bus.rsp_nzcv, e.nzcv);
      end
      exp_ptr = (int'(e.id) + 1) % 4;
      pt();
   endtask

   task automatic test_rotation();
      exp_t e; int g; int nr; int last_acc; int last_rsp;
      int ids [5] = '{0, 1, 2, 3, 0};
      reset_n = 1'b0; pt(); reset_n = 1'b1; exp_ptr = 0; q.delete();
      op[0] = OP_AND;  a[0] = 32'hF0F0_1234; b[0] = 32'h0FF0_FFFF;
      op[1] = OP_XOR;  a[1] = 32'hAAAA_5555; b[1] = 32'hFFFF_0000;
      op[2] = OP_SUB;  a[2] = 32'd3;         b[2] = 32'd3;
      op[3] = OP_NOTA; a[3] = 32'd0;         b[3] = 32'h1234_5678;
      nr = 0; last_acc = -1; last_rsp = -1;
      v = 4'b1111; #1;
      for (int t = 0; t < 40 && nr < 5; t++) begin
         if (bus.req_ready !== 4'b0000) begin
            g = pick(v, exp_ptr);
            n_chk++;
            if (bus.req_ready !== 4'(1 << g)) begin
               n_fail++; $display("FAIL rot_grant: got %b want %b", bus.req_ready, 4'(1 << g));
            end
            if (last_acc >= 0) begin
               n_chk++;
               if (t - last_acc !== 3) begin
                  n_fail++; $display("FAIL rot_accept_gap: got %0d want 3", t - last_acc);
               end
            end
            last_acc = t;
            q.push_back(mk(g));
         end
         if (bus.rsp_valid) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rot_unexpected_rsp: got id %0d want none", bus.rsp_id);
            end else begin
               e = q.pop_front();
               if ({bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err} !== {e.id, e.res, e.nzcv, e.err}
                   || int'(bus.rsp_id) != ids[nr]) begin
                  n_fail++; $display("FAIL rot_rsp%0d: got %h want %h (id %0d)", nr,
                     {bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err}, {e.id, e.res, e.nzcv, e.err}, ids[nr]);
               end
               exp_ptr = (int'(e.id) + 1) % 4;
            end
            if (last_rsp >= 0) begin
               n_chk++;
               if (t - last_rsp !== 3) begin
                  n_fail++; $display("FAIL rot_rsp_gap: got %0d want 3", t - last_rsp);
               end
            end
            last_rsp = t;
            nr++;
         end
         pt();
      end
      v = 4'b0000;
      n_chk++;
      if (nr !== 5) begin n_fail++; $display("FAIL rot_count: got %0d want 5", nr); end
   endtask

   task automatic test_illegal();
      exp_t e;
      op[2] = 3'b111; a[2] = 32'hDEAD_BEEF; b[2] = 32'h1234_5678; v = 4'b0100; #1;
      n_chk++;
      if (bus.req_ready !== 4'(1 << pick(v, exp_ptr))) begin
         n_fail++; $display("FAIL ill_grant: got %b want %b", bus.req_ready, 4'(1 << pick(v, exp_ptr)));
      end
      q.push_back(mk(2));
      pt(); v = 4'b0000;
      n_chk++;
      if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL ill_latency: got rsp_valid %b want 1", bus.rsp_valid); end
      n_chk++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 67'd0) begin
         n_fail++; $display("FAIL ill_alu_driven: got %h want 0", {bus.alu_op, bus.alu_a, bus.alu_b});
      end
      n_chk++;
      if ({bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err} !== {2'd2, 32'd0, 4'd0, 1'b1}) begin
         n_fail++; $display("FAIL ill_rsp: got %h want %h",
            {bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err}, {2'd2, 32'd0, 4'd0, 1'b1});
      end
      e = q.pop_front();
      exp_ptr = (int'(e.id) + 1) % 4;
      pt();
   endtask

   task automatic test_back_pressure();
      exp_t e; int n;
      rdy = 1'b0;
      op[3] = OP_OR; a[3] = 32'h1234_0000; b[3] = 32'h0000_5678; v = 4'b1000; #1;
      n_chk++;
      if (bus.req_ready !== 4'(1 << pick(v, exp_ptr))) begin
         n_fail++; $display("FAIL bp_grant: got %b want %b", bus.req_ready, 4'(1 << pick(v, exp_ptr)));
      end
      q.push_back(mk(3));
      pt(); v = 4'b1111;
      wait_rsp(n);
      n_chk++;
      if (n !== 1) begin n_fail++; $display("FAIL bp_latency: got %0d want 1", n); end
      e = q.pop_front();
      for (int k = 0; k < 5; k++) begin
         n_chk++;
         if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err, bus.req_ready}
             !== {1'b1, e.id, e.res, e.nzcv, e.err, 4'b0000}) begin
            n_fail++; $display("FAIL bp_hold%0d: got %h want %h", k,
               {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err, bus.req_ready},
               {1'b1, e.id, e.res, e.nzcv, e.err, 4'b0000});
         end
         pt();
      end
      rdy = 1'b1; #1;
      n_chk++;
      if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_hs_grant: got %b want 0000", bus.req_ready); end
      exp_ptr = (int'(e.id) + 1) % 4;
      pt();
      n_chk++;
      if (bus.req_ready !== 4'(1 << pick(v, exp_ptr))) begin
         n_fail++; $display("FAIL bp_resume: got %b want %b", bus.req_ready, 4'(1 << pick(v, exp_ptr)));
      end
      q.push_back(mk(pick(v, exp_ptr)));
      pt(); v = 4'b0000;
      wait_rsp(n);
      e = q.pop_front();
      n_chk++;
      if (n < 0 || {bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err} !== {e.id, e.res, e.nzcv, e.err}) begin
         n_fail++; $display("FAIL bp_next_rsp: got %h want %h (wait %0d)",
            {bus.rsp_id, bus.rsp_result, bus.rsp_nzcv, bus.rsp_err}, {e.id, e.res, e.nzcv, e.err}, n);
      end
      exp_ptr = (int'(e.id) + 1) % 4;
      pt();
   endtask

   task automatic test_reset_mid_exec();
      logic [35:0] m; int n; int held; int seen;
      op4[0] = OP_SUB; a4[0] = 32'd5; b4[0] = 32'd7;
      op4[1] = OP_SUB; a4[1] = 32'd5; b4[1] = 32'd7;
      m = alu_model(3'd5, 32'd5, 32'd7);
      v4 = 4'b0001; #1;
      n_chk++;
      if (bus4.req_ready !== 4'b0001) begin n_fail++; $display("FAIL lat4_grant: got %b want 0001", bus4.req_ready); end
      pt(); v4 = 4'b0000;
      n = -1; held = 0;
      for (int k = 1; k <= 20; k++) begin
         if (bus4.rsp_valid) begin n = k; break; end
         if (bus4.alu_op == 3'd5 && bus4.alu_a == 32'd5 && bus4.alu_b == 32'd7) held++;
         pt();
      end
      n_chk++;
      if (n !== 5 || held !== 4) begin
         n_fail++; $display("FAIL lat4_timing: got latency %0d hold %0d want 5 and 4", n, held);
      end
      n_chk++;
      if ({bus4.rsp_id, bus4.rsp_result, bus4.rsp_nzcv, bus4.rsp_err} !== {2'd0, m[31:0], m[35:32], 1'b0}) begin
         n_fail++; $display("FAIL lat4_rsp: got %h want %h",
            {bus4.rsp_id, bus4.rsp_result, bus4.rsp_nzcv, bus4.rsp_err}, {2'd0, m[31:0], m[35:32], 1'b0});
      end
      pt();
      v4 = 4'b0010; #1;
      n_chk++;
      if (bus4.req_ready !== 4'b0010) begin n_fail++; $display("FAIL lat4_grant2: got %b want 0010", bus4.req_ready); end
      pt(); v4 = 4'b0000;
      pt();
      reset_n4 = 1'b0; #2; reset_n4 = 1'b1;
      seen = 0;
      repeat (8) begin
         pt();
         if (bus4.rsp_valid !== 1'b0 || bus4.busy !== 1'b0) seen++;
      end
      n_chk++;
      if (seen !== 0) begin n_fail++; $display("FAIL mid_reset_rsp: got %0d active cycles want 0", seen); end
      v4 = 4'b1111; #1;
      n_chk++;
      if (bus4.req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_ptr: got %b want 0001", bus4.req_ready); end
      v4 = 4'b0000;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_rotation();
      test_illegal();
      test_back_pressure();
      test_reset_mid_exec();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion want finish before 200000");
      $fatal(1, "watchdog expired");
   end
endmodule
